// File: rtl/lamp_seq_checker_if.sv
// Lamp bus plus decoded status from the tail-lamp checker.
// The sequencer side is the master; the checker is the slave.
interface lamp_seq_checker_if #(
    parameter int CNT_W = 8
);
    logic [5:0]       LAMPS;
    logic [1:0]       DIR;
    logic [1:0]       PHASE;
    logic             SWEEP;
    logic [CNT_W-1:0] SWEEPS;
    logic             ERR;
    logic [1:0]       ERR_CODE;

    modport master (
        output LAMPS,
        input  DIR, PHASE, SWEEP, SWEEPS, ERR, ERR_CODE
    );

    modport slave (
        input  LAMPS,
        output DIR, PHASE, SWEEP, SWEEPS, ERR, ERR_CODE
    );
endinterface

// File: rtl/lamp_seq_checker.sv
// Decodes the 6-bit tail-lamp bus into direction/phase, counts sweeps and
// latches the first illegal pattern, transition or stall.
module lamp_seq_checker #(
    parameter int CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    lamp_seq_checker_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_R1, S_R2, S_R3, S_L1, S_L2, S_L3, S_RESYNC
    } state_t;

    state_t           state, nxt, pat_st;
    logic             legal, is_r, is_l, trans_ok;
    logic             err_ev, sweep_ev;
    logic [1:0]       code_ev;
    logic [1:0]       dir_q, phase_q, dir_n, phase_n, code_q;
    logic             sweep_q, err_q;
    logic [CNT_W-1:0] sweeps_q;

    // Map the sampled bus onto the state it would represent.
    always_comb begin
        legal  = 1'b1;
        pat_st = S_IDLE;
        case (bus.LAMPS)
            6'b000000: pat_st = S_IDLE;
            6'b000100: pat_st = S_R1;
            6'b000110: pat_st = S_R2;
            6'b000111: pat_st = S_R3;
            6'b001000: pat_st = S_L1;
            6'b011000: pat_st = S_L2;
            6'b111000: pat_st = S_L3;
            default:   legal  = 1'b0;
        endcase
    end

    always_comb begin
        is_r = (state == S_R1) || (state == S_R2) || (state == S_R3);
        is_l = (state == S_L1) || (state == S_L2) || (state == S_L3);
        trans_ok = (pat_st == S_IDLE)
                || (state == S_IDLE && (pat_st == S_R1 || pat_st == S_L1))
                || (state == S_R1 && pat_st == S_R2)
                || (state == S_R2 && pat_st == S_R3)
                || (state == S_R3 && pat_st == S_R1)
                || (state == S_L1 && pat_st == S_L2)
                || (state == S_L2 && pat_st == S_L3)
                || (state == S_L3 && pat_st == S_L1)
                || (is_r && pat_st == S_L1)
                || (is_l && pat_st == S_R1);
    end

    // RESYNC never raises a new error; it only waits for a clean entry pattern.
    always_comb begin
        nxt      = state;
        err_ev   = 1'b0;
        code_ev  = 2'b00;
        sweep_ev = 1'b0;
        if (state == S_RESYNC) begin
            if (legal && (pat_st == S_IDLE || pat_st == S_R1 || pat_st == S_L1))
                nxt = pat_st;
        end else if (!legal) begin
            err_ev  = 1'b1;
            code_ev = 2'b01;
        end else if (pat_st == state && state != S_IDLE) begin
            err_ev  = 1'b1;
            code_ev = 2'b11;
        end else if (trans_ok) begin
            nxt      = pat_st;
            sweep_ev = (pat_st == S_R3) || (pat_st == S_L3);
        end else begin
            err_ev  = 1'b1;
            code_ev = 2'b10;
        end
        if (err_ev)
            nxt = S_RESYNC;
    end

    always_comb begin
        dir_n   = 2'b00;
        phase_n = 2'd0;
        case (nxt)
            S_R1: begin dir_n = 2'b01; phase_n = 2'd1; end
            S_R2: begin dir_n = 2'b01; phase_n = 2'd2; end
            S_R3: begin dir_n = 2'b01; phase_n = 2'd3; end
            S_L1: begin dir_n = 2'b10; phase_n = 2'd1; end
            S_L2: begin dir_n = 2'b10; phase_n = 2'd2; end
            S_L3: begin dir_n = 2'b10; phase_n = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            dir_q    <= 2'b00;
            phase_q  <= 2'd0;
            sweep_q  <= 1'b0;
            sweeps_q <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state   <= nxt;
            dir_q   <= dir_n;
            phase_q <= phase_n;
            sweep_q <= sweep_ev;
            if (sweep_ev && sweeps_q != {CNT_W{1'b1}})
                sweeps_q <= sweeps_q + 1'b1;
            if (err_ev) begin
                err_q <= 1'b1;
                if (!err_q)
                    code_q <= code_ev;
            end
        end
    end

    assign bus.DIR      = dir_q;
    assign bus.PHASE    = phase_q;
    assign bus.SWEEP    = sweep_q;
    assign bus.SWEEPS   = sweeps_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CODE = code_q;
endmodule

// File: tb/tb_lamp_seq_checker.sv
// Directed scoreboard bench: stimulus queues expected status, a monitor
// pops and compares one entry per clock for each of two checker instances.
module tb_lamp_seq_checker;
    localparam logic [5:0] OFF = 6'b000000;
    localparam logic [5:0] R1  = 6'b000100, R2 = 6'b000110, R3 = 6'b000111;
    localparam logic [5:0] L1  = 6'b001000, L2 = 6'b011000, L3 = 6'b111000;

    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] phase;
        logic       sweep;
        logic [7:0] sweeps;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q2[$];

    lamp_seq_checker_if #(.CNT_W(8)) bus1 ();
    lamp_seq_checker_if #(.CNT_W(2)) bus2 ();

    lamp_seq_checker #(.CNT_W(8)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));
    lamp_seq_checker #(.CNT_W(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2.slave));

    always #5 CLK = ~CLK;

    task automatic step1(input logic rst, input logic [5:0] lamps, input logic [1:0] dir,
                         input logic [1:0] ph, input logic sw, input int cnt,
                         input logic err, input logic [1:0] code);
        exp_t e;
        @(negedge CLK);
        RST = rst;
        bus1.LAMPS = lamps;
        e.dir = dir; e.phase = ph; e.sweep = sw; e.sweeps = 8'(cnt);
        e.err = err; e.code = code;
        q1.push_back(e);
    endtask

    task automatic step2(input logic [5:0] lamps, input logic [1:0] dir, input logic [1:0] ph,
                         input logic sw, input int cnt);
        exp_t e;
        @(negedge CLK);
        RST = 1'b0;
        bus2.LAMPS = lamps;
        e.dir = dir; e.phase = ph; e.sweep = sw; e.sweeps = 8'(cnt);
        e.err = 1'b0; e.code = 2'b00;
        q2.push_back(e);
    endtask

    // Monitor: status is presented every cycle, so one entry is checked per edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {bus1.DIR, bus1.PHASE, bus1.SWEEP, bus1.SWEEPS, bus1.ERR, bus1.ERR_CODE};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL dut1 #%0d: got dir=%b ph=%0d sw=%b cnt=%0d err=%b code=%b, want dir=%b ph=%0d sw=%b cnt=%0d err=%b code=%b",
                             total, a.dir, a.phase, a.sweep, a.sweeps, a.err, a.code,
                             e.dir, e.phase, e.sweep, e.sweeps, e.err, e.code);
                end
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                a = {bus2.DIR, bus2.PHASE, bus2.SWEEP, 6'b0, bus2.SWEEPS, bus2.ERR, bus2.ERR_CODE};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL dut2 #%0d: got dir=%b ph=%0d sw=%b cnt=%0d err=%b, want dir=%b ph=%0d sw=%b cnt=%0d err=%b",
                             total, a.dir, a.phase, a.sweep, a.sweeps, a.err,
                             e.dir, e.phase, e.sweep, e.sweeps, e.err);
                end
            end
        end
    end

    initial begin
        bus1.LAMPS = OFF;
        bus2.LAMPS = OFF;
        bus1.LAMPS = 6'b111111;
        step1(1, 6'b111111, 2'b00, 0, 0, 0, 0, 2'b00);   // lamps ignored under reset
        // Right sweeps twice
        step1(0, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, R1,  2'b01, 1, 0, 0, 0, 2'b00);
        step1(0, R2,  2'b01, 2, 0, 0, 0, 2'b00);
        step1(0, R3,  2'b01, 3, 1, 1, 0, 2'b00);
        step1(0, R1,  2'b01, 1, 0, 1, 0, 2'b00);
        step1(0, R2,  2'b01, 2, 0, 1, 0, 2'b00);
        step1(0, R3,  2'b01, 3, 1, 2, 0, 2'b00);
        step1(0, L1,  2'b10, 1, 0, 2, 0, 2'b00);          // R3 -> L1 direction change
        // Left sweep, change to right, then off
        step1(1, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, L1,  2'b10, 1, 0, 0, 0, 2'b00);
        step1(0, L2,  2'b10, 2, 0, 0, 0, 2'b00);
        step1(0, L3,  2'b10, 3, 1, 1, 0, 2'b00);
        step1(0, R1,  2'b01, 1, 0, 1, 0, 2'b00);
        step1(0, OFF, 2'b00, 0, 0, 1, 0, 2'b00);
        step1(0, OFF, 2'b00, 0, 0, 1, 0, 2'b00);
        // R2 -> L1 mid-sweep direction change, no sweep
        step1(0, R1,  2'b01, 1, 0, 1, 0, 2'b00);
        step1(0, R2,  2'b01, 2, 0, 1, 0, 2'b00);
        step1(0, L1,  2'b10, 1, 0, 1, 0, 2'b00);
        // Illegal pattern, RESYNC hold, exit on R1; later errors keep code 01
        step1(1, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, 6'b000010, 2'b00, 0, 0, 0, 1, 2'b01);
        step1(0, R2,  2'b00, 0, 0, 0, 1, 2'b01);
        step1(0, R1,  2'b01, 1, 0, 0, 1, 2'b01);
        step1(0, R1,  2'b00, 0, 0, 0, 1, 2'b01);          // stall, code kept
        step1(0, OFF, 2'b00, 0, 0, 0, 1, 2'b01);
        // Stall then L2 stays in RESYNC
        step1(1, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, R1,  2'b01, 1, 0, 0, 0, 2'b00);
        step1(0, R2,  2'b01, 2, 0, 0, 0, 2'b00);
        step1(0, R2,  2'b00, 0, 0, 0, 1, 2'b11);
        step1(0, L2,  2'b00, 0, 0, 0, 1, 2'b11);
        step1(0, L1,  2'b10, 1, 0, 0, 1, 2'b11);
        // Illegal transition into R3 gives error, never a sweep
        step1(1, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, R1,  2'b01, 1, 0, 0, 0, 2'b00);
        step1(0, R3,  2'b00, 0, 0, 0, 1, 2'b10);
        // Reset mid-sweep, then L3 is an illegal transition from IDLE
        step1(1, OFF, 2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, L1,  2'b10, 1, 0, 0, 0, 2'b00);
        step1(0, L2,  2'b10, 2, 0, 0, 0, 2'b00);
        step1(1, L2,  2'b00, 0, 0, 0, 0, 2'b00);
        step1(0, L3,  2'b00, 0, 0, 0, 1, 2'b10);
        // Narrow counter saturates at 3, pulses on every completion
        for (int i = 0; i < 8; i++) begin
            step2(R1, 2'b01, 1, 0, (i < 3) ? i : 3);
            step2(R2, 2'b01, 2, 0, (i < 3) ? i : 3);
            step2(R3, 2'b01, 3, 1, (i < 2) ? i + 1 : 3);
        end
        step2(OFF, 2'b00, 0, 0, 3);
        repeat (4) @(posedge CLK);
        #2;
        if (q1.size() != 0 || q2.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d entries left, want 0", q1.size(), q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lamp_seq_checker.md
# lamp_seq_checker

- Receive-side decoder and checker for the 6-bit tail-lamp bus driven by the turn-signal sequencer.
- Samples the lamp bus every clock and recovers the active direction and sweep phase.
- Counts completed sweeps and flags illegal patterns, illegal transitions and stalls.
- Sits on the lamp bus next to the sequencer, in the same clock domain, and drives status to the dashboard and fault logic.

## Interface
- CNT_W, default 8: width of the sweep counter.
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- LAMPS  input  6  lamp bus, bit order {L_outer, L_middle, L_inner, R_inner, R_middle, R_outer}.
- DIR  output  2  decoded direction: 00 none, 01 right, 10 left. 11 is never driven.
- PHASE  output  2  sweep phase 0..3; 0 when DIR=00.
- SWEEP  output  1  one-cycle pulse when a sweep completes.
- SWEEPS  output  CNT_W  count of completed sweeps; saturates at all-ones.
- ERR  output  1  sticky error flag; cleared only by RST.
- ERR_CODE  output  2  code of the first error since reset: 01 illegal pattern, 10 illegal transition, 11 stall.

## Operation
- Legal patterns:
  - OFF = 000000
  - R1 = 000100, R2 = 000110, R3 = 000111
  - L1 = 001000, L2 = 011000, L3 = 111000
- FSM states: IDLE, R1, R2, R3, L1, L2, L3, RESYNC. On RST the FSM enters IDLE.
- Legal transitions (current state -> sampled LAMPS):
  - any state except RESYNC -> OFF: go to IDLE.
  - IDLE -> OFF: stay in IDLE.
  - IDLE -> R1 or L1.
  - R1 -> R2 -> R3 -> R1.
  - L1 -> L2 -> L3 -> L1.
  - any R state -> L1, and any L state -> R1 (direction change).
- Errors, evaluated in this priority order:
  1. Pattern not in the legal set: code 01.
  2. Repeat of the same non-OFF pattern while in the matching R/L state: code 11 (stall).
  3. Any other transition not listed above: code 10.
- On an error:
  - ERR is set.
  - ERR_CODE is loaded only if ERR was 0 before that edge, so it keeps the first error.
  - FSM goes to RESYNC.
- RESYNC behaviour:
  - DIR=00, PHASE=0.
  - Exits to IDLE on OFF, to R1 on R1, to L1 on L1.
  - Any other sample keeps it in RESYNC with no new error raised.
- Output mapping:
  - DIR/PHASE follow the FSM state: Rn gives 01/n, Ln gives 10/n; IDLE and RESYNC give 00/0.
- Sweep completion:
  - Counted on a legal transition into R3 or L3.
  - SWEEP=1 for that one cycle.
  - SWEEPS increments by 1 and holds at 2^CNT_W-1, with no wrap.
  - SWEEP still pulses when the counter is saturated.

## Timing
- On an edge with RST=1, every output becomes 0: DIR=00, PHASE=0, SWEEP=0, SWEEPS=0, ERR=0, ERR_CODE=00. The LAMPS value on that edge is ignored.
- Latency is one clock: LAMPS sampled at edge k produces DIR/PHASE/SWEEP/ERR valid after edge k.
- All outputs are registered, with no combinational path from LAMPS.
- RST mid-sweep abandons tracking. The next edge compares against IDLE, so R2 arriving directly after reset is code 10.
- A pattern held for one cycle only is legal as long as each transition is legal; there is no minimum dwell time.
- An error and a sweep completion cannot occur on the same edge: the error takes precedence and SWEEP stays 0.
- A direction change straight to the opposite phase 1 (for example R2 -> L1) is legal and produces no SWEEP.

## Test plan
- Reset, then LAMPS OFF, R1, R2, R3, R1, R2, R3 on successive edges:
  - DIR=01 and PHASE goes 1,2,3,1,2,3.
  - SWEEP pulses after the 4th and 7th edges; SWEEPS=2; ERR=0.
- Left sweep L1, L2, L3, then R1, then OFF:
  - DIR goes 10,10,10,01,00.
  - SWEEPS=1; ERR=0.
- From IDLE apply 000010 (illegal pattern), then 000110, then R1:
  - ERR=1, ERR_CODE=01, DIR=00 after the first edge.
  - Stays in RESYNC after the second edge.
  - DIR=01, PHASE=1 after the third edge; ERR stays 1, ERR_CODE stays 01.
- R1, R2, R2 (stall), then L2:
  - ERR_CODE=11 after the third edge.
  - L2 leaves the FSM in RESYNC and ERR_CODE is unchanged.
- CNT_W=2, eight complete right sweeps:
  - SWEEPS saturates at 3.
  - SWEEP still pulses on every completion.
- Mid-sweep at L2, assert RST for one edge, then drive L3:
  - All outputs are 0 after the reset edge.
  - L3 then gives ERR=1, ERR_CODE=10.
